line_cmd_sequencer: RTL and testbench

- Command queue and issue sequencer that sits directly upstream of the line engine.
- The CPU memory-mapped register logic pushes complete line descriptors (color, x0, y0, x1, y1) in a single write.
- The block buffers them in a small FIFO and replays each one into the engine using the engine's setup protocol.
- Protocol per line: color strobe, four point strobes on a shared 10-bit bus, trigger. The block then waits for the engine to return to ready before issuing the next line.

---
 rtl/line_cmd_sequencer_if.sv | 37 +++
 rtl/line_cmd_sequencer.sv | 161 ++++++++++++++++
 tb/tb_line_cmd_sequencer.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/line_cmd_sequencer_if.sv
// Bundle between the CPU register block, line_cmd_sequencer and the line engine.
// The sequencer uses the slave modport; the register block/engine side uses master.
interface line_cmd_sequencer_if #(
   parameter int unsigned PTR_W = 2
);
   logic             cmd_wr_en;
   logic [31:0]      cmd_color;
   logic [9:0]       cmd_x0;
   logic [9:0]       cmd_y0;
   logic [9:0]       cmd_x1;
   logic [9:0]       cmd_y1;
   logic             cmd_full;
   logic [PTR_W:0]   cmd_count;
   logic             seq_idle;
   logic             LE_ready;
   logic [31:0]      LE_color;
   logic [9:0]       LE_point;
   logic             LE_color_valid;
   logic             LE_x0_valid;
   logic             LE_y0_valid;
   logic             LE_x1_valid;
   logic             LE_y1_valid;
   logic             LE_trigger;
   logic [31:0]      lines_issued;

   modport slave (
      input  cmd_wr_en, cmd_color, cmd_x0, cmd_y0, cmd_x1, cmd_y1, LE_ready,
      output cmd_full, cmd_count, seq_idle, LE_color, LE_point, LE_color_valid,
             LE_x0_valid, LE_y0_valid, LE_x1_valid, LE_y1_valid, LE_trigger, lines_issued
   );

   modport master (
      output cmd_wr_en, cmd_color, cmd_x0, cmd_y0, cmd_x1, cmd_y1, LE_ready,
      input  cmd_full, cmd_count, seq_idle, LE_color, LE_point, LE_color_valid,
             LE_x0_valid, LE_y0_valid, LE_x1_valid, LE_y1_valid, LE_trigger, lines_issued
   );
endinterface

// File: rtl/line_cmd_sequencer.sv
// Queues line descriptors and replays each into the line engine's setup protocol.
// Define LINE_SEQ_STATS_EN to build the lines_issued counter; otherwise it reads 0.
module line_cmd_sequencer #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned PTR_W = 2
) (
   input logic                 clk,
   input logic                 rst,
   line_cmd_sequencer_if.slave bus
);

   typedef struct packed {
      logic [31:0] color;
      logic [9:0]  x0;
      logic [9:0]  y0;
      logic [9:0]  x1;
      logic [9:0]  y1;
   } line_desc_t;

   typedef enum logic [2:0] {
      StIdle, StColor, StX0, StY0, StX1, StY1, StTrig, StDrain
   } state_t;

   line_desc_t       mem [DEPTH];
   line_desc_t       head;
   line_desc_t       cur_q;
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [PTR_W:0]   count_q, count_d;
   logic             full;
   logic             push, pop;
   state_t           state_q, state_d;

   // Strobe bits: [0] color, [1] x0, [2] y0, [3] x1, [4] y1, [5] trigger.
   logic [5:0]       strobe_q, strobe_d;
   logic [31:0]      color_q, color_d;
   logic [9:0]       point_q, point_d;

   assign head = mem[rd_ptr_q];
   assign full = (count_q == (PTR_W+1)'(DEPTH));
   assign push = bus.cmd_wr_en && !full;
   assign pop  = (state_q == StIdle) && (state_d == StColor);

   always_comb begin
      count_d = count_q;
      unique case ({push, pop})
         2'b10:   count_d = count_q + (PTR_W+1)'(1);
         2'b01:   count_d = count_q - (PTR_W+1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_q] <= '{color: bus.cmd_color, x0: bus.cmd_x0, y0: bus.cmd_y0,
                            x1: bus.cmd_x1, y1: bus.cmd_y1};
      end
      if (pop) cur_q <= head;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (count_q != '0 && bus.LE_ready) state_d = StColor;
         StColor: state_d = StX0;
         StX0:    state_d = StY0;
         StY0:    state_d = StX1;
         StX1:    state_d = StY1;
         StY1:    state_d = StTrig;
         StTrig:  state_d = StDrain;
         StDrain: if (bus.LE_ready) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Outputs are decoded from the next state so they register in step with it.
   always_comb begin
      strobe_d = '0;
      color_d  = color_q;
      point_d  = point_q;
      unique case (state_d)
         StColor: begin
            strobe_d[0] = 1'b1;
            color_d     = head.color;
         end
         StX0: begin
            strobe_d[1] = 1'b1;
            point_d     = cur_q.x0;
         end
         StY0: begin
            strobe_d[2] = 1'b1;
            point_d     = cur_q.y0;
         end
         StX1: begin
            strobe_d[3] = 1'b1;
            point_d     = cur_q.x1;
         end
         StY1: begin
            strobe_d[4] = 1'b1;
            point_d     = cur_q.y1;
         end
         StTrig:  strobe_d[5] = 1'b1;
         default: strobe_d = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         strobe_q <= '0;
         color_q  <= '0;
         point_q  <= '0;
      end else begin
         state_q  <= state_d;
         strobe_q <= strobe_d;
         color_q  <= color_d;
         point_q  <= point_d;
      end
   end

   assign bus.cmd_full       = full;
   assign bus.cmd_count      = count_q;
   assign bus.seq_idle       = (state_q == StIdle) && (count_q == '0);
   assign bus.LE_color       = color_q;
   assign bus.LE_point       = point_q;
   assign bus.LE_color_valid = strobe_q[0];
   assign bus.LE_x0_valid    = strobe_q[1];
   assign bus.LE_y0_valid    = strobe_q[2];
   assign bus.LE_x1_valid    = strobe_q[3];
   assign bus.LE_y1_valid    = strobe_q[4];
   assign bus.LE_trigger     = strobe_q[5];

`ifdef LINE_SEQ_STATS_EN
   logic [31:0] issued_q;

   // Counts in the same cycle the trigger strobe is visible.
   always_ff @(posedge clk) begin
      if (rst) begin
         issued_q <= '0;
      end else if (state_d == StTrig) begin
         issued_q <= issued_q + 32'd1;
      end
   end

   assign bus.lines_issued = issued_q;
`else
   assign bus.lines_issued = 32'd0;
`endif

endmodule

// File: tb/tb_line_cmd_sequencer.sv
// Bench for line_cmd_sequencer: queue/issue model checked every cycle plus directed scenarios.
module tb_line_cmd_sequencer;
   localparam int DEPTH = 4;
   localparam int PTR_W = 2;

   typedef struct packed {
      logic [31:0] color;
      logic [9:0]  x0;
      logic [9:0]  y0;
      logic [9:0]  x1;
      logic [9:0]  y1;
   } desc_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   line_cmd_sequencer_if #(.PTR_W(PTR_W)) bus ();

   line_cmd_sequencer #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int    checks = 0;
   int    errors = 0;
   int    cyc = 0;
   desc_t issued[$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   // Engine stand-in: drops ready after the color strobe, raises it busy_len cycles after trigger.
   bit auto_eng = 1'b0;
   bit manual_ready = 1'b1;
   bit eng_ready = 1'b1;
   int busy_len = 0;
   int busy_cnt = -1;
   int rise_cyc = 0;

   always begin
      @(negedge clk);
      #1;
      if (rst) begin
         eng_ready = 1'b1;
         busy_cnt  = -1;
      end else if (bus.LE_color_valid) begin
         eng_ready = 1'b0;
         busy_cnt  = -1;
      end else if (bus.LE_trigger) begin
         busy_cnt = busy_len;
      end else if (busy_cnt > 0) begin
         busy_cnt--;
      end else if (busy_cnt == 0) begin
         eng_ready = 1'b1;
         busy_cnt  = -1;
         rise_cyc  = cyc;
      end
      bus.LE_ready = auto_eng ? eng_ready : manual_ready;
   end

   // Reference model: descriptor queue plus the line-issue timing rules.
   initial begin : model
      desc_t       mq[$];
      desc_t       mcur;
      desc_t       nd;
      bit          inflight;
      bit          drain;
      bit          trig_prev;
      bit          ecol;
      int          sp;
      int          pre_size;
      logic [31:0] hcol;
      logic [9:0]  hpt;
      logic [31:0] mstat;
      logic [5:0]  exp_s;
      logic [5:0]  act_s;
      inflight = 0; drain = 0; trig_prev = 0; sp = 0;
      hcol = '0; hpt = '0; mstat = '0; mcur = '0;
      forever begin
         @(posedge clk);
         #1;
         exp_s = '0;
         if (rst) begin
            mq.delete();
            inflight = 0; drain = 0; trig_prev = 0; sp = 0;
            hcol = '0; hpt = '0; mstat = '0;
         end else begin
            pre_size = mq.size();
            ecol = !inflight && (pre_size > 0) && bus.LE_ready;
            if (bus.cmd_wr_en && pre_size < DEPTH) begin
               nd.color = bus.cmd_color;
               nd.x0 = bus.cmd_x0; nd.y0 = bus.cmd_y0;
               nd.x1 = bus.cmd_x1; nd.y1 = bus.cmd_y1;
               mq.push_back(nd);
            end
            if (drain && bus.LE_ready) begin
               drain = 0;
               inflight = 0;
            end
            if (trig_prev) drain = 1;
            trig_prev = 0;
            exp_s[0] = ecol;
            if (sp >= 1 && sp <= 5) exp_s = exp_s | (6'd1 << sp);
            case (sp)
               1: hpt = mcur.x0;
               2: hpt = mcur.y0;
               3: hpt = mcur.x1;
               4: hpt = mcur.y1;
               5: begin
                  mstat = mstat + 32'd1;
                  trig_prev = 1;
                  issued.push_back(mcur);
               end
               default: ;
            endcase
            if (ecol) begin
               mcur = mq.pop_front();
               inflight = 1;
               hcol = mcur.color;
               sp = 1;
            end else if (sp >= 1 && sp < 5) begin
               sp++;
            end else begin
               sp = 0;
            end
         end
`ifndef LINE_SEQ_STATS_EN
         mstat = '0;
`endif
         act_s = {bus.LE_trigger, bus.LE_y1_valid, bus.LE_x1_valid, bus.LE_y0_valid,
                  bus.LE_x0_valid, bus.LE_color_valid};
         chk("strobes", act_s, exp_s);
         chk("LE_color", bus.LE_color, hcol);
         chk("LE_point", bus.LE_point, hpt);
         chk("cmd_count", bus.cmd_count, mq.size());
         chk("cmd_full", bus.cmd_full, mq.size() == DEPTH);
         chk("seq_idle", bus.seq_idle, (mq.size() == 0) && !inflight);
         chk("lines_issued", bus.lines_issued, mstat);
      end
   end

   task automatic push(input logic [31:0] c, input logic [9:0] a, input logic [9:0] b,
                       input logic [9:0] d, input logic [9:0] e);
      @(negedge clk);
      bus.cmd_wr_en = 1'b1;
      bus.cmd_color = c;
      bus.cmd_x0 = a; bus.cmd_y0 = b; bus.cmd_x1 = d; bus.cmd_y1 = e;
   endtask

   task automatic stop_push();
      @(negedge clk);
      bus.cmd_wr_en = 1'b0;
   endtask

   task automatic push_when_room(input int i, input int base);
      int n = 0;
      while (bus.cmd_full && n < 100) begin
         @(negedge clk);
         n++;
      end
      push(32'h0000_1000 + i, 10'(base + i), 10'(base + 1 + i), 10'(base + 2 + i),
           10'(base + 3 + i));
      stop_push();
   endtask

   task automatic wait_idle(input string name, input int budget);
      int n = 0;
      do begin
         step();
         n++;
      end while (!bus.seq_idle && n < budget);
      chk(name, bus.seq_idle, 1);
   endtask

   initial begin : stim
      int n;
      int base;
      int t;
      bus.cmd_wr_en = 1'b0; bus.cmd_color = '0;
      bus.cmd_x0 = '0; bus.cmd_y0 = '0; bus.cmd_x1 = '0; bus.cmd_y1 = '0;
      bus.LE_ready = 1'b1;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      step();
      chk("reset_idle", bus.seq_idle, 1);
      chk("reset_count", bus.cmd_count, 0);
      chk("reset_color", bus.LE_color, 0);
      chk("reset_stats", bus.lines_issued, 0);

      // Single line, engine ready throughout.
      push(32'h00FF0000, 10'd10, 10'd20, 10'd100, 10'd40);
      stop_push();
      n = 0;
      do begin step(); n++; end while (!bus.LE_color_valid && n < 20);
      chk("single_color_strobe", bus.LE_color_valid, 1);
      chk("single_color", bus.LE_color, 32'h00FF0000);
      step(); chk("single_x0", {bus.LE_x0_valid, bus.LE_point}, {1'b1, 10'd10});
      step(); chk("single_y0", {bus.LE_y0_valid, bus.LE_point}, {1'b1, 10'd20});
      step(); chk("single_x1", {bus.LE_x1_valid, bus.LE_point}, {1'b1, 10'd100});
      step(); chk("single_y1", {bus.LE_y1_valid, bus.LE_point}, {1'b1, 10'd40});
      step(); chk("single_trig", bus.LE_trigger, 1);
      wait_idle("single_idle", 20);

      // Backpressure: engine busy for 50 cycles with two lines queued behind.
      @(negedge clk);
      auto_eng = 1'b1;
      busy_len = 50;
      push(32'h0000_0A01, 10'd1, 10'd2, 10'd3, 10'd4);
      push(32'h0000_0A02, 10'd5, 10'd6, 10'd7, 10'd8);
      push(32'h0000_0A03, 10'd9, 10'd10, 10'd11, 10'd12);
      stop_push();
      n = 0;
      do begin step(); n++; end while (!bus.LE_trigger && n < 40);
      chk("bp_first_trig", bus.LE_trigger, 1);
      repeat (30) step();
      chk("bp_count_held", bus.cmd_count, 2);
      chk("bp_quiet", {bus.LE_color_valid, bus.LE_trigger}, 0);
      n = 0;
      do begin step(); n++; end while (!bus.LE_color_valid && n < 100);
      chk("bp_next_color", bus.LE_color, 32'h0000_0A02);
      chk("bp_resume_gap", cyc - rise_cyc, 2);
      busy_len = 1;
      wait_idle("bp_idle", 300);

      // Full: five pushes with the engine held not-ready.
      @(negedge clk);
      auto_eng = 1'b0;
      manual_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         push(32'h0000_0100 + i, 10'(100 + i), 10'(110 + i), 10'(120 + i), 10'(130 + i));
      end
      stop_push();
      step();
      chk("full_flag", bus.cmd_full, 1);
      chk("full_count", bus.cmd_count, 4);
      base = issued.size();
      @(negedge clk);
      auto_eng = 1'b1;
      wait_idle("full_idle", 200);
      chk("full_issued", issued.size() - base, 4);
      for (int i = 0; i < 4; i++) begin
         if (issued.size() > base + i) begin
            chk("full_order", {issued[base + i].color[15:0], 6'd0, issued[base + i].x0},
                {16'h0100 + 16'(i), 6'd0, 10'(100 + i)});
         end
      end

      // Wrap: ten lines through the queue with interleaved pushes.
      base = issued.size();
      for (int i = 0; i < 10; i++) begin
         push_when_room(i, 200);
         @(negedge clk);
      end
      wait_idle("wrap_idle", 400);
      chk("wrap_issued", issued.size() - base, 10);
      for (int i = 0; i < 10; i++) begin
         if (issued.size() > base + i) begin
            chk("wrap_order", {issued[base + i].x0, issued[base + i].y1},
                {10'(200 + i), 10'(203 + i)});
         end
      end

      // Reset during the y0 strobe abandons the line and the queued entry.
      push(32'h0000_0E01, 10'd50, 10'd51, 10'd52, 10'd53);
      push(32'h0000_0E02, 10'd60, 10'd61, 10'd62, 10'd63);
      stop_push();
      n = 0;
      do begin step(); n++; end while (!bus.LE_y0_valid && n < 30);
      chk("rst_y0_seen", bus.LE_y0_valid, 1);
      @(negedge clk);
      rst = 1'b1;
      step();
      chk("rst_strobes",
          {bus.LE_color_valid, bus.LE_x0_valid, bus.LE_y0_valid, bus.LE_x1_valid,
           bus.LE_y1_valid, bus.LE_trigger}, 0);
      chk("rst_mid_count", bus.cmd_count, 0);
      chk("rst_mid_idle", bus.seq_idle, 1);
      chk("rst_mid_point", bus.LE_point, 0);
      @(negedge clk);
      rst = 1'b0;
      t = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (bus.LE_trigger) t++;
      end
      chk("rst_no_trig", t, 0);

      // Stats: six lines after reset.
      for (int i = 0; i < 6; i++) push_when_room(i, 300);
      wait_idle("stats_idle", 300);
`ifdef LINE_SEQ_STATS_EN
      chk("stats_six", bus.lines_issued, 6);
`else
      chk("stats_off", bus.lines_issued, 0);
`endif

      repeat (2) step();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
